// File: rtl/spi_ram_responder_pkg.sv
// Shared SPI RAM definitions: opcodes, responder FSM encoding and opcode helpers.
// spi_master is expected to import the same opcodes from here.
package spi_ram_responder_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddrHi,
    StAddrLo,
    StRead,
    StWrite,
    StIgnore
  } rsp_state_e;

  function automatic logic is_supported_cmd(input logic [7:0] op);
    return (op == CMD_READ) || (op == CMD_WRITE);
  endfunction

endpackage

// File: rtl/spi_ram_responder_if.sv
// SPI RAM bus: master drives clock, select and MOSI; the responder drives MISO and its enable.
interface spi_ram_responder_if;
  logic spi_sclk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sclk,
    output spi_cs,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a registered edge detector.
module spi_pin_sync #(
  parameter int unsigned SyncStages = 2,
  parameter bit          ResetVal   = 1'b0
) (
  input  logic clk_core_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk_core_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin_i};
      prev_q <= sync_q[SyncStages-1];
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 slave emulating a 23LC512-style sequential serial SRAM (READ/WRITE, 16-bit address),
// oversampling the SPI pins in the core clock domain.
module spi_ram_responder
  import spi_ram_responder_pkg::*;
#(
  parameter int unsigned MemDepth   = 1024,
  parameter int unsigned SyncStages = 2
) (
  input  logic                      clk_core_i,
  input  logic                      rst_i,
  spi_ram_responder_if.slave        spi,
  output logic                      busy_o,
  output logic                      wr_strobe_o,
  output logic [15:0]               wr_addr_o,
  output logic [7:0]                wr_data_o,
  output logic                      cmd_error_o
);

  localparam int unsigned IdxW = $clog2(MemDepth);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_pin_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_sclk (
    .clk_core_i (clk_core_i),
    .rst_i      (rst_i),
    .pin_i      (spi.spi_sclk),
    .level_o    (sclk_lvl),
    .rise_o     (sclk_rise),
    .fall_o     (sclk_fall)
  );

  spi_pin_sync #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_cs (
    .clk_core_i (clk_core_i),
    .rst_i      (rst_i),
    .pin_i      (spi.spi_cs),
    .level_o    (cs_lvl),
    .rise_o     (cs_rise),
    .fall_o     (cs_fall)
  );

  spi_pin_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_mosi (
    .clk_core_i (clk_core_i),
    .rst_i      (rst_i),
    .pin_i      (spi.spi_mosi),
    .level_o    (mosi_lvl),
    .rise_o     (mosi_rise),
    .fall_o     (mosi_fall)
  );

  logic unused_pins;
  assign unused_pins = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  rsp_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rx_byte;
  logic [15:0] addr_q, addr_d;
  logic        is_read_q, is_read_d;
  logic [6:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        busy_q, busy_d;
  logic        prefetch_q, prefetch_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        cmd_error_q, cmd_error_d;
  logic [7:0]  rd_byte_q;

  logic [7:0]  mem [MemDepth];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    busy_d      = busy_q;
    prefetch_d  = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cmd_error_d = 1'b0;
    rx_byte     = {rx_q[6:0], mosi_lvl};

    if (cs_rise) begin
      // Any partial byte is simply dropped with the state.
      state_d = StIdle;
      busy_d  = 1'b0;
      miso_d  = 1'b0;
    end else if (cs_fall) begin
      state_d   = StCmd;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b1;
      miso_d    = 1'b0;
    end else if (state_q != StIdle && state_q != StIgnore) begin
      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = rx_byte;
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            StCmd: begin
              if (is_supported_cmd(rx_byte)) begin
                state_d   = StAddrHi;
                is_read_d = (rx_byte == CMD_READ);
              end else begin
                state_d     = StIgnore;
                cmd_error_d = 1'b1;
              end
            end
            StAddrHi: begin
              addr_d[15:8] = rx_byte;
              state_d      = StAddrLo;
            end
            StAddrLo: begin
              addr_d[7:0] = rx_byte;
              state_d     = is_read_q ? StRead : StWrite;
              prefetch_d  = is_read_q;
            end
            StRead: begin
              addr_d     = addr_q + 16'd1;
              prefetch_d = 1'b1;
            end
            StWrite: begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = rx_byte;
              addr_d      = addr_q + 16'd1;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_q == StRead) begin
        if (bit_cnt_q == 3'd0) begin
          miso_d = rd_byte_q[7];
          tx_d   = rd_byte_q[6:0];
        end else begin
          miso_d = tx_q[6];
          tx_d   = {tx_q[5:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk_core_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'd0;
      addr_q      <= 16'd0;
      is_read_q   <= 1'b0;
      tx_q        <= 7'd0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      prefetch_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 16'd0;
      wr_data_q   <= 8'd0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      prefetch_q  <= prefetch_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  // Single-port store: commits lag the strobe by a cycle and never collide with a prefetch.
  always_ff @(posedge clk_core_i) begin
    if (wr_strobe_q) begin
      mem[wr_addr_q[IdxW-1:0]] <= wr_data_q;
    end else if (prefetch_q) begin
      rd_byte_q <= mem[addr_q[IdxW-1:0]];
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = busy_q;
  assign busy_o          = busy_q;
  assign wr_strobe_o     = wr_strobe_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign cmd_error_o     = cmd_error_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Randomized scoreboard bench for spi_ram_responder driving the bus as an SPI master.
module tb_spi_ram_responder;
  import spi_ram_responder_pkg::*;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Sync  = 2;
  localparam int          H     = 6;

  typedef logic [7:0] byte_q_t[$];

  logic        clk_core = 1'b0;
  logic        rst;
  logic        busy, wr_strobe, cmd_error;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  spi_ram_responder_if bus ();

  spi_ram_responder #(.MemDepth(Depth), .SyncStages(Sync)) dut (
    .clk_core_i  (clk_core),
    .rst_i       (rst),
    .spi         (bus),
    .busy_o      (busy),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .cmd_error_o (cmd_error)
  );

  always #5 clk_core = ~clk_core;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [Depth];
  logic [23:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  bit          exp_err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write strobes and opcode errors are checked as the DUT presents them.
  always @(negedge clk_core) begin
    if (!rst) begin
      if (wr_strobe) begin
        check("wr_strobe_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          logic [23:0] e;
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[23:8]));
          check("wr_data", 32'(wr_data), 32'(e[7:0]));
        end
      end
      if (cmd_error) begin
        check("cmd_error_expected", 32'(exp_err_q.size() != 0), 32'd1);
        if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
      end
    end
  end

  // Bus monitor: assembles read data on SCLK rises and watches MISO stays low elsewhere.
  int unsigned mon_bits;
  logic [7:0]  mon_cmd, mon_rx;
  logic        mon_stray;
  logic        mon_active = 1'b0;

  always @(negedge bus.spi_cs) begin
    mon_bits   = 0;
    mon_cmd    = 8'd0;
    mon_rx     = 8'd0;
    mon_stray  = 1'b0;
    mon_active = 1'b1;
  end

  always @(posedge bus.spi_sclk) begin
    if (mon_active && !bus.spi_cs) begin
      mon_bits++;
      if (mon_bits <= 8) mon_cmd = {mon_cmd[6:0], bus.spi_mosi};
      if (mon_cmd == CMD_READ && mon_bits > 24) begin
        mon_rx = {mon_rx[6:0], bus.spi_miso};
        if (mon_bits % 8 == 0) begin
          check("rd_byte_expected", 32'(exp_rd_q.size() != 0), 32'd1);
          if (exp_rd_q.size() != 0) check("rd_data", 32'(mon_rx), 32'(exp_rd_q.pop_front()));
        end
      end else if (bus.spi_miso !== 1'b0) begin
        mon_stray = 1'b1;
      end
    end
  end

  always @(posedge bus.spi_cs) begin
    if (mon_active) begin
      mon_active = 1'b0;
      check("miso_low_outside_read", 32'(mon_stray), 32'd0);
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    bus.spi_mosi = b;
    clk_wait(H);
    bus.spi_sclk = 1'b1;
    clk_wait(H);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_begin();
    bus.spi_cs = 1'b0;
    clk_wait(H);
  endtask

  task automatic cs_end();
    clk_wait(H);
    bus.spi_cs = 1'b1;
    clk_wait(3 * H);
  endtask

  task automatic do_write(input logic [15:0] addr, input byte_q_t data);
    logic [15:0] a;
    cs_begin();
    spi_byte(CMD_WRITE);
    spi_byte(addr[15:8]);
    check("busy_oe_selected", 32'({busy, bus.spi_miso_oe}), 32'd3);
    spi_byte(addr[7:0]);
    for (int i = 0; i < data.size(); i++) begin
      a = addr + 16'(i);
      exp_wr_q.push_back({a, data[i]});
      ref_mem[int'(a) % Depth] = data[i];
      spi_byte(data[i]);
    end
    cs_end();
  endtask

  task automatic do_read(input logic [15:0] addr, input int n);
    logic [15:0] a;
    cs_begin();
    spi_byte(CMD_READ);
    spi_byte(addr[15:8]);
    spi_byte(addr[7:0]);
    for (int i = 0; i < n; i++) begin
      a = addr + 16'(i);
      exp_rd_q.push_back(ref_mem[int'(a) % Depth]);
      spi_byte(8'($urandom));
    end
    cs_end();
  endtask

  task automatic do_bad(input logic [7:0] op);
    cs_begin();
    exp_err_q.push_back(1'b1);
    spi_byte(op);
    for (int i = 0; i < 3; i++) spi_byte(8'($urandom));
    cs_end();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    byte_q_t     d;
    logic [15:0] a;
    logic [7:0]  op;
    int          len;

    rst          = 1'b1;
    bus.spi_cs   = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    clk_wait(5);
    check("reset_outputs", 32'({bus.spi_miso, bus.spi_miso_oe, busy, wr_strobe, wr_addr, wr_data,
                                cmd_error}), 32'd0);
    rst = 1'b0;
    clk_wait(5);

    d = '{8'hA5};
    do_write(16'h0010, d);
    d = '{8'h3C, 8'hC3};
    do_write(16'h0020, d);
    do_read(16'h0020, 2);

    // Index wraps at Depth-1 -> 0, and 0x0400 aliases 0x0000.
    d = '{8'h11};
    do_write(16'h03FF, d);
    d = '{8'h22};
    do_write(16'h0000, d);
    do_read(16'h03FF, 2);
    d = '{8'h77};
    do_write(16'h0400, d);
    do_read(16'h0000, 1);

    do_bad(8'h05);

    // Abort a write after five data bits.
    d = '{8'h5A};
    do_write(16'h0040, d);
    cs_begin();
    spi_byte(CMD_WRITE);
    spi_byte(8'h00);
    spi_byte(8'h40);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    clk_wait(H);
    bus.spi_cs = 1'b1;
    clk_wait(Sync + 2);
    check("busy_drop_after_abort", 32'(busy), 32'd0);
    clk_wait(3 * H);
    do_read(16'h0040, 1);

    // Reset in the middle of the address phase.
    d = '{8'h9E};
    do_write(16'h0123, d);
    cs_begin();
    spi_byte(CMD_READ);
    spi_byte(8'h01);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    rst = 1'b1;
    clk_wait(2);
    check("mid_reset_outputs", 32'({bus.spi_miso, bus.spi_miso_oe, busy, wr_strobe, wr_addr,
                                    wr_data, cmd_error}), 32'd0);
    bus.spi_cs = 1'b1;
    clk_wait(3);
    rst = 1'b0;
    clk_wait(3 * H);
    do_read(16'h0123, 1);

    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 8'($urandom); while (op == CMD_READ || op == CMD_WRITE);
        do_bad(op);
      end else begin
        a   = 16'($urandom);
        len = $urandom_range(1, 3);
        d   = {};
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
        do_write(a, d);
        do_read(a, len);
      end
    end

    clk_wait(20);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("err_queue_drained", 32'(exp_err_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
